// File: rtl/lii_in_unpack_wrapper.sv
// lii_in_unpack_wrapper
//   Receive side of the LII phy link. Each packed beat arriving on phy input
//   channel p0 is split into two kernel streams:
//     stream0 <= tdata[2*DW-1:DW] (upper field)
//     stream1 <= tdata[DW-1:0]    (lower field)
//   Each stream has its own holding slot, and the two slots drain
//   independently. A new beat is taken only when both slots are empty or are
//   emptying this cycle, so one packed word is never split across two beats.
//   Bits of tdata above 2*DW are ignored.
//
// Optional feature (macro LII_DST_CHECK_EN):
//   A beat whose dst differs from NODE_ID is consumed and dropped. Such beats
//   are accepted regardless of slot occupancy, and a 16-bit saturating drop
//   counter is exposed on the extra port drop_cnt.
//
// Ports:
//   aclk, arstn          clock, asynchronous active-low reset
//   lii_in_p0_*          packed phy input channel (tdata/tvalid/tready/src/dst)
//   stream0_*, stream1_* unpacked kernel streams (tdata/tvalid/tready)
//   last_src             src of the most recently delivered beat
//   ce                   kernel clock enable, high while both slots hold data
//   drop_cnt             dropped-beat counter (LII_DST_CHECK_EN only)

module lii_in_unpack_wrapper #(
    parameter int unsigned PW      = 512,
    parameter int unsigned DW      = 256,
    parameter logic [7:0]  NODE_ID = 8'h00
) (
    input  logic            aclk,
    input  logic            arstn,

    input  logic [PW-1:0]   lii_in_p0_tdata,
    input  logic            lii_in_p0_tvalid,
    output logic            lii_in_p0_tready,
    input  logic [7:0]      lii_in_p0_src,
    input  logic [7:0]      lii_in_p0_dst,

    output logic [DW-1:0]   stream0_tdata,
    output logic            stream0_tvalid,
    input  logic            stream0_tready,

    output logic [DW-1:0]   stream1_tdata,
    output logic            stream1_tvalid,
    input  logic            stream1_tready,

    output logic [7:0]      last_src,
`ifdef LII_DST_CHECK_EN
    output logic [15:0]     drop_cnt,
`endif
    output logic            ce
);

    localparam int unsigned SRC_W = 8;
    localparam int unsigned CNT_W = 16;

    // Holding slots, one per kernel stream
    logic              slot0_v_q, slot0_v_d;
    logic              slot1_v_q, slot1_v_d;
    logic [DW-1:0]     slot0_q,   slot0_d;
    logic [DW-1:0]     slot1_q,   slot1_d;
    logic [SRC_W-1:0]  last_src_q, last_src_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    // Goes high one cycle after reset release; holds off the link until then
    logic              sync_ok_q;

    logic              fire0_c;
    logic              fire1_c;
    logic              room_c;
    logic              foreign_c;
    logic              tready_c;
    logic              accept_c;
    logic              deliver_c;

    // Handshake and acceptance decode
    always_comb begin
        fire0_c   = slot0_v_q & stream0_tready;
        fire1_c   = slot1_v_q & stream1_tready;
        // Both slots must be free (or freeing now) so a beat lands atomically
        room_c    = (~slot0_v_q | fire0_c) & (~slot1_v_q | fire1_c);
`ifdef LII_DST_CHECK_EN
        foreign_c = (lii_in_p0_dst != NODE_ID);
        // Foreign traffic is always sunk so the link never stalls on it
        tready_c  = sync_ok_q & (foreign_c | room_c);
`else
        foreign_c = 1'b0;
        tready_c  = sync_ok_q & room_c;
`endif
        accept_c  = lii_in_p0_tvalid & tready_c;
        deliver_c = accept_c & ~foreign_c;
    end

    // Next-state for slots, last_src and drop counter
    always_comb begin
        slot0_v_d  = slot0_v_q;
        slot1_v_d  = slot1_v_q;
        slot0_d    = slot0_q;
        slot1_d    = slot1_q;
        last_src_d = last_src_q;
        drop_cnt_d = drop_cnt_q;

        if (fire0_c) begin
            slot0_v_d = 1'b0;
        end
        if (fire1_c) begin
            slot1_v_d = 1'b0;
        end

        // A delivery overrides a same-cycle drain: back-to-back refill
        if (deliver_c) begin
            slot0_v_d  = 1'b1;
            slot1_v_d  = 1'b1;
            slot0_d    = lii_in_p0_tdata[2*DW-1:DW];
            slot1_d    = lii_in_p0_tdata[DW-1:0];
            last_src_d = lii_in_p0_src;
        end

        if (accept_c && foreign_c && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    // State registers
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            sync_ok_q  <= 1'b0;
            slot0_v_q  <= 1'b0;
            slot1_v_q  <= 1'b0;
            slot0_q    <= '0;
            slot1_q    <= '0;
            last_src_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            sync_ok_q  <= 1'b1;
            slot0_v_q  <= slot0_v_d;
            slot1_v_q  <= slot1_v_d;
            slot0_q    <= slot0_d;
            slot1_q    <= slot1_d;
            last_src_q <= last_src_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Output mapping
    assign lii_in_p0_tready = tready_c;
    assign stream0_tdata    = slot0_q;
    assign stream0_tvalid   = slot0_v_q;
    assign stream1_tdata    = slot1_q;
    assign stream1_tvalid   = slot1_v_q;
    assign last_src         = last_src_q;
    // Kernel runs only while both inputs are presented
    assign ce               = slot0_v_q & slot1_v_q;

`ifdef LII_DST_CHECK_EN
    assign drop_cnt = drop_cnt_q;
`else
    // Without the dst check the counter is constant and dst is unused
    logic unused_nodst;
    assign unused_nodst = ^{lii_in_p0_dst, drop_cnt_q};
`endif

    // Packing bits above the two fields carry nothing for this node
    generate
        if (PW > 2*DW) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^lii_in_p0_tdata[PW-1:2*DW];
        end
    endgenerate

endmodule

// File: tb/tb_lii_in_unpack_wrapper.sv
// Scoreboard bench for lii_in_unpack_wrapper: the driver pushes the expected
// per-stream payload on each accepted beat, a negedge monitor pops and
// compares whenever a stream handshake fires.
module tb_lii_in_unpack_wrapper;

    localparam int unsigned PW = 72;
    localparam int unsigned DW = 32;

    logic            aclk;
    logic            arstn;
    logic [PW-1:0]   lii_in_p0_tdata;
    logic            lii_in_p0_tvalid;
    logic            lii_in_p0_tready;
    logic [7:0]      lii_in_p0_src;
    logic [7:0]      lii_in_p0_dst;
    logic [DW-1:0]   stream0_tdata;
    logic            stream0_tvalid;
    logic            stream0_tready;
    logic [DW-1:0]   stream1_tdata;
    logic            stream1_tvalid;
    logic            stream1_tready;
    logic [7:0]      last_src;
    logic            ce;
`ifdef LII_DST_CHECK_EN
    logic [15:0]     drop_cnt;
`endif

    lii_in_unpack_wrapper #(.PW(PW), .DW(DW), .NODE_ID(8'h03)) dut (
        .aclk             (aclk),
        .arstn            (arstn),
        .lii_in_p0_tdata  (lii_in_p0_tdata),
        .lii_in_p0_tvalid (lii_in_p0_tvalid),
        .lii_in_p0_tready (lii_in_p0_tready),
        .lii_in_p0_src    (lii_in_p0_src),
        .lii_in_p0_dst    (lii_in_p0_dst),
        .stream0_tdata    (stream0_tdata),
        .stream0_tvalid   (stream0_tvalid),
        .stream0_tready   (stream0_tready),
        .stream1_tdata    (stream1_tdata),
        .stream1_tvalid   (stream1_tvalid),
        .stream1_tready   (stream1_tready),
        .last_src         (last_src),
`ifdef LII_DST_CHECK_EN
        .drop_cnt         (drop_cnt),
`endif
        .ce               (ce)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [7:0]    src;
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    int         n_checks;
    int         n_errors;
    logic [7:0] model_src;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit delivered(input logic [7:0] dst);
`ifdef LII_DST_CHECK_EN
        return (dst == 8'h03);
`else
        return (dst == dst);
`endif
    endfunction

    // Monitor: compare each fired stream word against the scoreboard
    always @(negedge aclk) begin
        exp_t e;
        if (arstn === 1'b1 && stream0_tvalid === 1'b1 && stream0_tready === 1'b1) begin
            n_checks++;
            if (q0.size() == 0) begin
                n_errors++;
                $display("FAIL s0_unexpected: got %0h expected nothing", stream0_tdata);
            end else begin
                e = q0.pop_front();
                n_checks--;
                check("s0_data", 64'(stream0_tdata), 64'(e.d));
                check("s0_last_src", 64'(last_src), 64'(e.src));
            end
        end
        if (arstn === 1'b1 && stream1_tvalid === 1'b1 && stream1_tready === 1'b1) begin
            n_checks++;
            if (q1.size() == 0) begin
                n_errors++;
                $display("FAIL s1_unexpected: got %0h expected nothing", stream1_tdata);
            end else begin
                e = q1.pop_front();
                n_checks--;
                check("s1_data", 64'(stream1_tdata), 64'(e.d));
            end
        end
    end

    // Present a beat, wait (bounded) for acceptance, push expectations
    task automatic send_beat(input logic [DW-1:0] up, input logic [DW-1:0] lo,
                             input logic [7:0] src, input logic [7:0] dst,
                             output int stalls);
        bit ok;
        lii_in_p0_tdata  = {8'hA5, up, lo};
        lii_in_p0_src    = src;
        lii_in_p0_dst    = dst;
        lii_in_p0_tvalid = 1'b1;
        stalls = 0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (lii_in_p0_tready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            stalls++;
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: got no tready expected accept src=%0h", src);
        end else begin
            if (delivered(dst)) begin
                q0.push_back('{d: up, src: src});
                q1.push_back('{d: lo, src: src});
                model_src = src;
            end
            @(posedge aclk);
            #1;
            check("last_src", 64'(last_src), 64'(model_src));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin
        int stalls;
        int total;
        n_checks = 0;
        n_errors = 0;
        model_src = 8'h00;
        arstn = 1'b0;
        lii_in_p0_tdata = '0;
        lii_in_p0_tvalid = 1'b0;
        lii_in_p0_src = '0;
        lii_in_p0_dst = '0;
        stream0_tready = 1'b0;
        stream1_tready = 1'b0;

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_s0v", 64'(stream0_tvalid), 64'd0);
        check("rst_s1v", 64'(stream1_tvalid), 64'd0);
        check("rst_tready", 64'(lii_in_p0_tready), 64'd0);
        check("rst_ce", 64'(ce), 64'd0);
        check("rst_last_src", 64'(last_src), 64'd0);
        check("rst_s0_data", 64'(stream0_tdata), 64'd0);
        check("rst_s1_data", 64'(stream1_tdata), 64'd0);
`ifdef LII_DST_CHECK_EN
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
`endif

        // Release with a beat already waiting: tready low in first cycle
        stream0_tready = 1'b1;
        stream1_tready = 1'b1;
        lii_in_p0_tdata = {8'hA5, 32'hA000_0000, 32'hB000_0000};
        lii_in_p0_src = 8'h05;
        lii_in_p0_dst = 8'h03;
        lii_in_p0_tvalid = 1'b1;
        #2 arstn = 1'b1;
        #1;
        check("tready_after_release", 64'(lii_in_p0_tready), 64'd0);

        // Eight beats at full throughput; src 05 then 09
        total = 0;
        for (int i = 0; i < 8; i++) begin
            send_beat(32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i),
                      (i < 4) ? 8'h05 : 8'h09, 8'h03, stalls);
            total += stalls;
        end
        lii_in_p0_tvalid = 1'b0;
        check("throughput_stalls", 64'(total), 64'd0);
        check("b2b_s0v", 64'(stream0_tvalid), 64'd1);
        check("b2b_s1v", 64'(stream1_tvalid), 64'd1);
        check("b2b_ce", 64'(ce), 64'd1);
        @(negedge aclk);
        @(posedge aclk);
        #1;
        check("drained_s0v", 64'(stream0_tvalid), 64'd0);
        check("drained_s1v", 64'(stream1_tvalid), 64'd0);
        check("drained_ce", 64'(ce), 64'd0);

        // Independent drain: stream1 held off
        stream1_tready = 1'b0;
        send_beat(32'hC0C0_C0C0, 32'hD0D0_D0D0, 8'h09, 8'h03, stalls);
        lii_in_p0_tvalid = 1'b0;
        check("split_ce_full", 64'(ce), 64'd1);
        @(negedge aclk);
        @(posedge aclk);
        #1;
        check("split_s0v", 64'(stream0_tvalid), 64'd0);
        check("split_s1v", 64'(stream1_tvalid), 64'd1);
        check("split_ce", 64'(ce), 64'd0);
        lii_in_p0_tdata = {8'hA5, 32'hE0E0_E0E0, 32'hF0F0_F0F0};
        lii_in_p0_src = 8'h05;
        lii_in_p0_tvalid = 1'b1;
        repeat (3) begin
            @(negedge aclk);
            check("split_tready", 64'(lii_in_p0_tready), 64'd0);
            check("split_s1_hold", 64'(stream1_tdata), 64'hD0D0_D0D0);
            check("split_s1v_hold", 64'(stream1_tvalid), 64'd1);
        end
        @(posedge aclk);
        #1;
        stream1_tready = 1'b1;
        send_beat(32'hE0E0_E0E0, 32'hF0F0_F0F0, 8'h05, 8'h03, stalls);
        lii_in_p0_tvalid = 1'b0;
        check("split_resume_stalls", 64'(stalls), 64'd0);
        @(negedge aclk);
        @(posedge aclk);
        #1;

        // Asynchronous reset with full slots
        stream0_tready = 1'b0;
        stream1_tready = 1'b0;
        send_beat(32'h1234_5678, 32'h9ABC_DEF0, 8'h0A, 8'h03, stalls);
        lii_in_p0_tvalid = 1'b0;
        @(negedge aclk);
        check("pre_rst_s0v", 64'(stream0_tvalid), 64'd1);
        #2 arstn = 1'b0;
        #1;
        check("arst_s0v", 64'(stream0_tvalid), 64'd0);
        check("arst_s1v", 64'(stream1_tvalid), 64'd0);
        check("arst_ce", 64'(ce), 64'd0);
        check("arst_last_src", 64'(last_src), 64'd0);
        check("arst_tready", 64'(lii_in_p0_tready), 64'd0);
        q0.delete();
        q1.delete();
        model_src = 8'h00;
        stream0_tready = 1'b1;
        stream1_tready = 1'b1;
        @(posedge aclk);
        #2 arstn = 1'b1;
        #1;
        check("rerelease_tready", 64'(lii_in_p0_tready), 64'd0);
        repeat (4) begin
            @(negedge aclk);
            check("post_rst_s0v", 64'(stream0_tvalid), 64'd0);
            check("post_rst_s1v", 64'(stream1_tvalid), 64'd0);
        end
        @(posedge aclk);
        #1;

        // Destination filtering
`ifdef LII_DST_CHECK_EN
        stream0_tready = 1'b0;
        stream1_tready = 1'b0;
        send_beat(32'h0000_0111, 32'h0000_0222, 8'h11, 8'h03, stalls);
        send_beat(32'h0000_0333, 32'h0000_0444, 8'h22, 8'h07, stalls);
        check("foreign_stalls", 64'(stalls), 64'd0);
        check("foreign_s0_hold", 64'(stream0_tdata), 64'h111);
        check("foreign_s1_hold", 64'(stream1_tdata), 64'h222);
        stream0_tready = 1'b1;
        stream1_tready = 1'b1;
        send_beat(32'h0000_0555, 32'h0000_0666, 8'h33, 8'h03, stalls);
        check("local_stalls", 64'(stalls), 64'd0);
        check("drop_cnt", 64'(drop_cnt), 64'd1);
`else
        send_beat(32'h0000_0111, 32'h0000_0222, 8'h11, 8'h03, stalls);
        send_beat(32'h0000_0333, 32'h0000_0444, 8'h22, 8'h07, stalls);
        send_beat(32'h0000_0555, 32'h0000_0666, 8'h33, 8'h03, stalls);
        check("dst_ignored_stalls", 64'(stalls), 64'd0);
`endif
        lii_in_p0_tvalid = 1'b0;

        repeat (5) @(negedge aclk);
        check("q0_empty", 64'(q0.size()), 64'd0);
        check("q1_empty", 64'(q1.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
